// File: rtl/bus_pkg.sv
// Shared definitions for the Bus_Ram bus layer arbiter.
// Contents: FSM state encodings, bus mux select codes, master indices,
// and small decode helpers used by bus_arb3.
package bus_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;
  localparam logic [1:0] ST_G2   = 2'd3;

  // Select codes for the existing 3:1 bus mux (d0=M0, d1=M1, d2=M2)
  localparam logic [1:0] SEL_M0 = 2'b00;
  localparam logic [1:0] SEL_M1 = 2'b01;
  localparam logic [1:0] SEL_M2 = 2'b10;

  // Master indices
  localparam logic [1:0] IDX_M0 = 2'd0;
  localparam logic [1:0] IDX_M1 = 2'd1;
  localparam logic [1:0] IDX_M2 = 2'd2;

  // Grant state that corresponds to a master index.
  function automatic logic [1:0] grant_state(input logic [1:0] idx);
    case (idx)
      IDX_M0:  grant_state = ST_G0;
      IDX_M1:  grant_state = ST_G1;
      default: grant_state = ST_G2;
    endcase
  endfunction

  // Mux select driven in each state; IDLE parks on M0 so 2'b11 never appears.
  function automatic logic [1:0] state_sel(input logic [1:0] st);
    case (st)
      ST_G1:   state_sel = SEL_M1;
      ST_G2:   state_sel = SEL_M2;
      default: state_sel = SEL_M0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports: req[2:0] request vector (bit n = Mn), last[1:0] previous owner index;
//        idx[1:0] chosen index, vld set when any request is present.
// Search starts at the master after 'last', so 'last' itself has lowest priority.
module rr_pick3
  import bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    vld = |req;
    idx = IDX_M0;
    case (last)
      IDX_M0: begin
        if      (req[1]) idx = IDX_M1;
        else if (req[2]) idx = IDX_M2;
        else             idx = IDX_M0;
      end
      IDX_M1: begin
        if      (req[2]) idx = IDX_M2;
        else if (req[0]) idx = IDX_M0;
        else             idx = IDX_M1;
      end
      default: begin
        if      (req[0]) idx = IDX_M0;
        else if (req[1]) idx = IDX_M1;
        else             idx = IDX_M2;
      end
    endcase
  end

endmodule

// File: rtl/bus_arb3.sv
// Round-robin arbiter sharing one 32-bit bus between masters M0, M1, M2.
// Ports: clk, reset (sync, active-high), m0/m1/m2_req in; one-hot m0/m1/m2_grant,
//        sel[1:0] for the 3:1 bus mux, busy out. Optional hold timeout: ARB_TIMEOUT_EN.
// Grant follows request by one cycle; owners are never preempted unless timeout is enabled.
module bus_arb3
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] sel,
  output logic       busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
    $error("bus_arb3: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  logic [2:0] req;
  logic [1:0] state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       owner_req;
  logic       timeout;

  assign req = {m2_req, m1_req, m0_req};

  // 'last' always equals the current owner while granted, so the owner is
  // searched last and any other requester wins the pick.
  rr_pick3 u_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_comb begin
    case (state)
      ST_G0:   owner_req = m0_req;
      ST_G1:   owner_req = m1_req;
      ST_G2:   owner_req = m2_req;
      default: owner_req = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // pick_idx != last means someone other than the owner is waiting.
  assign timeout = (state != ST_IDLE) &&
                   (hold_cnt == CNT_W'(MAX_HOLD - 1)) &&
                   pick_vld && (pick_idx != last);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state_nxt != state) begin
      hold_cnt <= '0;
    end else if (state != ST_IDLE && hold_cnt != {CNT_W{1'b1}}) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    if (state == ST_IDLE || !owner_req || timeout) begin
      if (pick_vld) begin
        state_nxt = grant_state(pick_idx);
        last_nxt  = pick_idx;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= IDX_M2;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Outputs are pure decodes of the state register.
  assign m0_grant = (state == ST_G0);
  assign m1_grant = (state == ST_G1);
  assign m2_grant = (state == ST_G2);
  assign sel      = state_sel(state);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_arb3.sv
// Self-checking bench for bus_arb3: table-driven directed vectors plus
// hand-written timeout/hold and random one-hot sequences.
module tb_bus_arb3;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m1_req, m2_req;
  logic       m0_grant, m1_grant, m2_grant;
  logic [1:0] sel;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arb3 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .m2_req   (m2_req),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m2_grant (m2_grant),
    .sel      (sel),
    .busy     (busy)
  );

  typedef struct packed {
    logic       rst;
    logic [2:0] req;  // {m2,m1,m0}
    logic [2:0] gnt;  // expected {m2,m1,m0}_grant after the edge
    logic [1:0] sel;  // expected sel after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [2:0] r);
    @(negedge clk);
    reset  = rst;
    m0_req = r[0];
    m1_req = r[1];
    m2_req = r[2];
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic [2:0] r, input logic [2:0] g, input logic [1:0] s);
    vec_t v;
    v.rst = rst; v.req = r; v.gnt = g; v.sel = s;
    vecs.push_back(v);
  endtask

  initial begin
    int first_m1;
    logic [2:0] g;
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;

    // Reset with all requests high, then release: M0 first.
    add(1, 3'b111, 3'b000, 2'b00);
    add(1, 3'b111, 3'b000, 2'b00);
    add(0, 3'b111, 3'b001, 2'b00);
    // Single master M1 for 5 cycles, then idle.
    add(1, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < 5; i++) add(0, 3'b010, 3'b010, 2'b01);
    add(0, 3'b000, 3'b000, 2'b00);
    add(0, 3'b000, 3'b000, 2'b00);
    // Fairness: each owner drops req after 3 grant cycles, then re-raises.
    add(1, 3'b000, 3'b000, 2'b00);
    add(0, 3'b111, 3'b001, 2'b00);
    add(0, 3'b111, 3'b001, 2'b00);
    add(0, 3'b111, 3'b001, 2'b00);
    add(0, 3'b110, 3'b010, 2'b01);
    add(0, 3'b111, 3'b010, 2'b01);
    add(0, 3'b111, 3'b010, 2'b01);
    add(0, 3'b101, 3'b100, 2'b10);
    add(0, 3'b111, 3'b100, 2'b10);
    add(0, 3'b111, 3'b100, 2'b10);
    add(0, 3'b011, 3'b001, 2'b00);
    // Reset mid-grant on M2; afterwards M0 wins over M2.
    add(0, 3'b100, 3'b100, 2'b10);
    add(1, 3'b101, 3'b000, 2'b00);
    add(0, 3'b101, 3'b001, 2'b00);
    add(0, 3'b101, 3'b001, 2'b00);
    add(0, 3'b100, 3'b100, 2'b10);
    add(0, 3'b000, 3'b000, 2'b00);
    // From IDLE with last=M2, simultaneous M1/M2 -> M1.
    add(0, 3'b110, 3'b010, 2'b01);
    add(0, 3'b000, 3'b000, 2'b00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d_grant", i), int'({m2_grant, m1_grant, m0_grant}), int'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i), int'(sel), int'(vecs[i].sel));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(|vecs[i].gnt));
    end

    // Hold/timeout: M0 requests alone, M1 joins one cycle later.
    step(1, 3'b000);
    step(0, 3'b001);
    check("hold_m0_first", int'(m0_grant), 1);
    first_m1 = 0;
    for (int c = 2; c <= 14; c++) begin
      step(0, 3'b011);
      if (m1_grant && first_m1 == 0) first_m1 = c;
    end
`ifdef ARB_TIMEOUT_EN
    check("timeout_m1_cycle", first_m1, 5);
`else
    check("hold_no_preempt", first_m1, 0);
    check("hold_m0_still", int'(m0_grant), 1);
    step(0, 3'b010);
    check("hold_release_m1", int'(m1_grant), 1);
    check("hold_release_sel", int'(sel), 1);
`endif
    step(0, 3'b000);
    step(1, 3'b000);

    // Random requests: grants at most one-hot, sel legal and consistent.
    for (int c = 0; c < 1000; c++) begin
      step(0, 3'($urandom_range(0, 7)));
      g = {m2_grant, m1_grant, m0_grant};
      check("rand_onehot", int'($countones(g) <= 1), 1);
      check("rand_sel_legal", int'(sel != 2'b11), 1);
      check("rand_sel_match", int'(sel), g[2] ? 2 : (g[1] ? 1 : 0));
      check("rand_busy", int'(busy), int'(|g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
